mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences the memory stage of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM register outputs: MemRead, MemWrite, ALU result used as the address, rd2 used as store data, and funct3.
- Runs a request/acknowledge transaction on the data-memory bus, with byte/halfword/word formatting and load sign/zero extension.
- Holds the pipeline with stall_o until the access completes. Includes an ack timeout.

Parameters:
ACK_TIMEOUT, 15, max cycles in REQ waiting for bus_ack_i before aborting with bus_err_o (1..255)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
mem_read_i  in  1  load request (EX/MEM MemRead)
mem_write_i  in  1  store request (EX/MEM MemWrite)
addr_i  in  32  byte address (EX/MEM ALU result)
wdata_i  in  32  store data (EX/MEM rd2)
funct3_i  in  3  access size/sign (EX/MEM funct3)
stall_o  out  1  hold IF/ID/EX/MEM pipeline registers
rdata_o  out  32  formatted load data for WB mux
rdata_valid_o  out  1  rdata_o valid (one-cycle pulse)
bus_req_o  out  1  bus request
bus_we_o  out  1  1 = write
bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata_o  out  32  lane-replicated store data
bus_be_o  out  4  byte enables
bus_ack_i  in  1  bus completion, single cycle
bus_rdata_i  in  32  read word, valid with bus_ack_i
bus_err_o  out  1  timeout pulse (one cycle, in DONE)
misalign_o  out  1  misaligned-access pulse (one cycle, in DONE); tied 0 without MISALIGN_TRAP_EN

Behaviour:
- Reset (async): state IDLE, timeout counter 0. All outputs 0: stall_o, rdata_o, rdata_valid_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_err_o, misalign_o.
- Reset asserted mid-REQ drops bus_req_o immediately. A late bus_ack_i after reset is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access = mem_read_i | mem_write_i.
  - stall_o = access, combinational, so the pipeline holds from the first cycle.
  - On access: latch addr, data, funct3 and we = mem_write_i. Write wins if both mem_read_i and mem_write_i are set.
  - Then go to REQ.
- REQ:
  - bus_req_o = 1 and stall_o = 1. Bus outputs are driven from latched values and are stable for the whole request.
  - Counter increments each cycle.
  - On bus_ack_i: capture formatted read data (loads only), go to DONE.
  - If the counter reaches ACK_TIMEOUT with no ack: bus_err_o = 1 in DONE, rdata_o = 0, go to DONE.
- DONE:
  - stall_o = 0 and rdata_valid_o = 1 (loads, or any error) for exactly one cycle; the pipeline advances.
  - Counter clears; next state IDLE.
  - An instruction present in IDLE the following cycle is a new access.
- Latency: load/store with ack in the first REQ cycle stalls 2 cycles (IDLE, REQ) and completes in cycle 3. Each extra wait cycle adds 1.
- Store formatting (funct3):
  - 000 SB: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - 001 SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - 010 SW: be = 4'b1111.
- Loads: bus_be_o = 4'b1111 on the bus.
  - Lane selected by addr[1:0] (byte) or addr[1] (half).
  - Sign extension: 000 LB, 001 LH. Zero extension: 100 LBU, 101 LHU. 010 LW passes the word through.
- Unused funct3 (011, 110, 111) is treated as a word access.
- rdata_o holds its value until the next load completes.
- bus_err_o and misalign_o are one-cycle pulses only.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, is detected in IDLE.
  - No bus request is issued; the FSM goes IDLE -> DONE directly (1 stall cycle).
  - misalign_o = 1 in DONE; rdata_o = 0 for loads; no bus write occurs.
- Undefined: no check is made and misalign_o is tied 0.
  - Halfword uses addr[1] only (addr[0] ignored); word ignores addr[1:0].
  - The access proceeds normally.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, ack in first REQ cycle -> stall_o high 2 cycles, rdata_o = 0xDEADBEEF with rdata_valid_o pulse in cycle 3, bus_addr_o = 0x100.
- SB addr 0x203, wdata 0x000000A5 -> bus_we_o = 1, bus_be_o = 4'b1000, bus_wdata_o = 0xA5A5A5A5, bus_addr_o = 0x200.
- LB addr 0x2, bus_rdata 0x00800000 -> rdata_o = 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x2, bus_rdata 0x80010000 -> 0x00008001.
- Load with no ack, ACK_TIMEOUT = 15 -> bus_req_o high 15 cycles, then bus_err_o pulse, rdata_o = 0, stall_o releases.
- Assert rst_n low during REQ, then send ack 2 cycles after reset release -> bus_req_o falls asynchronously, state IDLE, no rdata_valid_o.
- With MISALIGN_TRAP_EN: LW addr 0x102 -> bus_req_o never asserted, misalign_o pulse after 1 stall cycle. Without the macro -> normal access at 0x100.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - RISC-V MEM-stage bus sequencer with load/store formatting and ack timeout
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        access;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign access = mem_read_i | mem_write_i;

    // Stall is combinational in IDLE so the pipeline freezes in the request cycle itself.
    assign stall_o = rst_n & (((state == IDLE) & access) | (state == REQ));

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_i;
        case (funct3_i)
            3'b000: begin
                st_be    = 4'b0001 << addr_i[1:0];
                st_wdata = {4{wdata_i[7:0]}};
            end
            3'b001: begin
                st_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_i;
            end
        endcase
    end

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = word >> {off, 3'b000};
        half    = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  return {24'h0, shifted[7:0]};
            3'b001:  return {{16{half[15]}}, half};
            3'b101:  return {16'h0, half};
            default: return word;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic misalign_det;
    always_comb begin
        misalign_det = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: misalign_det = 1'b0;
            3'b001, 3'b101: misalign_det = addr_i[0];
            default:        misalign_det = (addr_i[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            off_q         <= 2'b00;
            f3_q          <= 3'b000;
            we_q          <= 1'b0;
            rdata_o       <= 32'h0;
            rdata_valid_o <= 1'b0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= 32'h0;
            bus_wdata_o   <= 32'h0;
            bus_be_o      <= 4'h0;
            bus_err_o     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o    <= 1'b0;
`endif
        end else begin
            rdata_valid_o <= 1'b0;
            bus_err_o     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (access) begin
                        we_q  <= mem_write_i;
                        off_q <= addr_i[1:0];
                        f3_q  <= funct3_i;
                        cnt   <= 8'd0;
`ifdef MISALIGN_TRAP_EN
                        if (misalign_det) begin
                            // Trap without touching the bus; loads return zero.
                            misalign_o    <= 1'b1;
                            rdata_valid_o <= 1'b1;
                            if (!mem_write_i) rdata_o <= 32'h0;
                            state <= DONE;
                        end else
`endif
                        begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_write_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_be_o    <= mem_write_i ? st_be : 4'b1111;
                            bus_wdata_o <= st_wdata;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        if (!we_q) begin
                            rdata_o       <= load_format(f3_q, off_q, bus_rdata_i);
                            rdata_valid_o <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                        bus_req_o     <= 1'b0;
                        bus_we_o      <= 1'b0;
                        bus_err_o     <= 1'b1;
                        rdata_valid_o <= 1'b1;
                        rdata_o       <= 32'h0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    cnt   <= 8'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
